// File: rtl/bf_loop_unit.sv
// bf_loop_unit: bracket-resolving stage between instruction fetch and decode of the Brainfuck core.
// Ports:
//    i_clk, i_reset              rising-edge clock, asynchronous active-high reset
//    i_op_pc, i_op, i_op_valid   opcode and its address from fetch; o_op_ack consumes it
//    o_out_op, o_out_valid       opcode forwarded to decode; i_out_ack accepts it
//    i_cell_valid, i_cell_zero   current data cell state, meaningful once downstream is drained
//    o_pc_load, o_pc_d           one-cycle program counter redirect for a repeating loop
//    o_flush                     one-cycle strobe telling fetch to discard its in-flight opcode
//    o_level                     return-stack occupancy
//    o_err                       sticky structural error (stack over/underflow, skip nesting overflow)
module bf_loop_unit #(
   parameter int IA_WIDTH = 12,
   parameter int ID_WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int SKIP_WIDTH = 8,
   parameter logic [ID_WIDTH-1:0] OP_OPEN = 'h5B,
   parameter logic [ID_WIDTH-1:0] OP_CLOSE = 'h5D,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [IA_WIDTH-1:0] i_op_pc,
   input  logic [ID_WIDTH-1:0] i_op,
   input  logic                i_op_valid,
   output logic                o_op_ack,
   output logic [ID_WIDTH-1:0] o_out_op,
   output logic                o_out_valid,
   input  logic                i_out_ack,
   input  logic                i_cell_valid,
   input  logic                i_cell_zero,
   output logic                o_pc_load,
   output logic [IA_WIDTH-1:0] o_pc_d,
   output logic                o_flush,
   output logic [LW-1:0]       o_level,
   output logic                o_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {PASS, WAIT_OPEN, WAIT_CLOSE, SKIP, REDIRECT, ERROR} state_t;
   state_t r_state;
   logic [IA_WIDTH-1:0] r_stack [DEPTH];
   logic [IA_WIDTH-1:0] r_open_pc;
   logic [IA_WIDTH-1:0] r_pc_d;
   logic [SKIP_WIDTH-1:0] r_skip;
   logic [LW-1:0] r_level;
   logic [ID_WIDTH-1:0] r_out_op;
   logic r_out_valid, r_pc_load, r_flush, r_err;
   logic w_open, w_close, w_bracket, w_ready, w_full, w_ack, w_fwd, w_push;
   logic [AW-1:0] w_top;
   assign w_open = i_op == OP_OPEN;
   assign w_close = i_op == OP_CLOSE;
   assign w_bracket = w_open || w_close;
   // The cell may only be judged once every forwarded opcode has left this stage.
   assign w_ready = !r_out_valid && i_cell_valid;
   assign w_full = r_level == LW'(DEPTH);
   assign w_top = AW'(r_level - LW'(1));
   // Brackets wait for an empty output register; other opcodes may overlap a draining one.
   assign w_ack = !i_reset && i_op_valid &&
                  (r_state == SKIP || (r_state == PASS && (!r_out_valid || (!w_bracket && i_out_ack))));
   assign w_fwd = w_ack && r_state == PASS && !w_bracket;
   assign w_push = r_state == WAIT_OPEN && w_ready && !i_cell_zero && !w_full;
   // Return addresses need no reset: occupancy alone defines which entries are live.
   always_ff @(posedge i_clk)
      if (w_push) r_stack[AW'(r_level)] <= r_open_pc;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= PASS;
         r_open_pc <= '0;
         r_pc_d <= '0;
         r_skip <= '0;
         r_level <= '0;
         r_out_op <= '0;
         r_out_valid <= 1'b0;
         r_pc_load <= 1'b0;
         r_flush <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_pc_load <= 1'b0;
         r_flush <= 1'b0;
         if (w_fwd) begin
            r_out_op <= i_op;
            r_out_valid <= 1'b1;
         end else if (i_out_ack) r_out_valid <= 1'b0;
         case (r_state)
            PASS:
               if (w_ack && w_bracket) begin
                  r_open_pc <= i_op_pc;
                  r_state <= w_open ? WAIT_OPEN : WAIT_CLOSE;
               end
            WAIT_OPEN:
               if (w_ready) begin
                  if (i_cell_zero) begin
                     r_skip <= SKIP_WIDTH'(1);
                     r_state <= SKIP;
                  end else if (w_full) begin
                     r_err <= 1'b1;
                     r_state <= ERROR;
                  end else begin
                     r_level <= r_level + LW'(1);
                     r_state <= PASS;
                  end
               end
            WAIT_CLOSE:
               if (w_ready) begin
                  if (r_level == '0) begin
                     r_err <= 1'b1;
                     r_state <= ERROR;
                  end else if (i_cell_zero) begin
                     r_level <= r_level - LW'(1);
                     r_state <= PASS;
                  end else begin
                     // Loop repeats: resume at the opcode after the matching '['.
                     r_pc_d <= r_stack[w_top] + IA_WIDTH'(1);
                     r_pc_load <= 1'b1;
                     r_flush <= 1'b1;
                     r_state <= REDIRECT;
                  end
               end
            REDIRECT: r_state <= PASS;
            SKIP:
               if (w_ack && w_open) begin
                  if (&r_skip) begin
                     r_err <= 1'b1;
                     r_state <= ERROR;
                  end else r_skip <= r_skip + SKIP_WIDTH'(1);
               end else if (w_ack && w_close) begin
                  r_skip <= r_skip - SKIP_WIDTH'(1);
                  if (r_skip == SKIP_WIDTH'(1)) r_state <= PASS;
               end
            ERROR: r_state <= ERROR;
            default: r_state <= ERROR;
         endcase
      end
   end
   assign o_op_ack = w_ack;
   assign o_out_op = r_out_op;
   assign o_out_valid = r_out_valid;
   assign o_pc_load = r_pc_load;
   assign o_pc_d = r_pc_d;
   assign o_flush = r_flush;
   assign o_level = r_level;
   assign o_err = r_err;
endmodule

// File: tb/tb_bf_loop_unit.sv
// tb_bf_loop_unit: drives bf_loop_unit as a small fetch/decode/data-memory harness and compares
// the executed opcode trace, loop redirects and error outcome with a plain Brainfuck interpreter.
module tb_bf_loop_unit;
   localparam int IAW = 12;
   localparam int D = 2;
   localparam int SW = 3;
   localparam int LW = $clog2(D + 1);
   localparam int SKMAX = (1 << SW) - 1;
   logic clk = 1'b0;
   logic rst;
   logic [IAW-1:0] op_pc;
   logic [7:0] op;
   logic op_valid, out_ack, cell_valid, cell_zero;
   logic o_op_ack, o_out_valid, o_pc_load, o_flush, o_err;
   logic [7:0] o_out_op;
   logic [IAW-1:0] o_pc_d;
   logic [LW-1:0] o_level;
   always #5 clk = ~clk;
   bf_loop_unit #(.IA_WIDTH(IAW), .ID_WIDTH(8), .DEPTH(D), .SKIP_WIDTH(SW),
                  .OP_OPEN(8'h5B), .OP_CLOSE(8'h5D)) dut (
      .i_clk(clk), .i_reset(rst), .i_op_pc(op_pc), .i_op(op), .i_op_valid(op_valid),
      .o_op_ack(o_op_ack), .o_out_op(o_out_op), .o_out_valid(o_out_valid), .i_out_ack(out_ack),
      .i_cell_valid(cell_valid), .i_cell_zero(cell_zero), .o_pc_load(o_pc_load), .o_pc_d(o_pc_d),
      .o_flush(o_flush), .o_level(o_level), .o_err(o_err)
   );
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] prog [256];
   int plen;
   logic [7:0] init_mem [16];
   logic [7:0] exp_trace [$];
   logic [7:0] act [$];
   int exp_tgt [$];
   int exp_err, exp_level, exp_maxd;
   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask
   task automatic load(input string s);
      for (int i = 0; i < s.len(); i++) prog[i] = s[i];
      plen = s.len();
   endtask
   task automatic add(input logic [7:0] c);
      prog[8'(plen)] = c;
      plen++;
   endtask
   task automatic set_mem(input logic [7:0] v);
      for (int i = 0; i < 16; i++) init_mem[i] = 8'd0;
      init_mem[0] = v;
   endtask
   // Plain interpreter: '[' skips by bracket counting, ']' jumps back via a stack of '[' addresses.
   task automatic ref_run();
      logic [7:0] rm [16];
      int stk [$];
      int pc = 0, p = 0, steps = 0, sk;
      logic [7:0] c;
      bit stop = 0;
      rm = init_mem;
      exp_trace.delete();
      exp_tgt.delete();
      exp_err = 0;
      exp_maxd = 0;
      while (pc < plen && !stop && steps < 100000) begin
         steps++;
         c = prog[8'(pc)];
         if (c == "[") begin
            if (rm[4'(p)] != 8'd0) begin
               if (stk.size() == D) begin
                  exp_err = 1;
                  stop = 1;
               end else begin
                  stk.push_back(pc);
                  if (stk.size() > exp_maxd) exp_maxd = stk.size();
                  pc++;
               end
            end else begin
               sk = 1;
               pc++;
               while (sk > 0 && pc < plen && !stop) begin
                  if (prog[8'(pc)] == "[") begin
                     if (sk == SKMAX) begin
                        exp_err = 1;
                        stop = 1;
                     end else sk++;
                  end else if (prog[8'(pc)] == "]") sk--;
                  pc++;
               end
            end
         end else if (c == "]") begin
            if (stk.size() == 0) begin
               exp_err = 1;
               stop = 1;
            end else if (rm[4'(p)] != 8'd0) begin
               pc = stk[$] + 1;
               exp_tgt.push_back(pc);
            end else begin
               void'(stk.pop_back());
               pc++;
            end
         end else begin
            exp_trace.push_back(c);
            if (c == "+") rm[4'(p)] = rm[4'(p)] + 8'd1;
            else if (c == "-") rm[4'(p)] = rm[4'(p)] - 8'd1;
            else if (c == ">") p++;
            else if (c == "<") p--;
            pc++;
         end
      end
      exp_level = stk.size();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      op_valid = 1'b0;
      op = 8'd0;
      op_pc = '0;
      out_ack = 1'b0;
      cell_valid = 1'b0;
      cell_zero = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic check_rst(input string tag);
      check({tag, ":op_ack"}, int'(o_op_ack), 0);
      check({tag, ":out_valid"}, int'(o_out_valid), 0);
      check({tag, ":out_op"}, int'(o_out_op), 0);
      check({tag, ":pc_load"}, int'(o_pc_load), 0);
      check({tag, ":pc_d"}, int'(o_pc_d), 0);
      check({tag, ":flush"}, int'(o_flush), 0);
      check({tag, ":err"}, int'(o_err), 0);
      check({tag, ":level"}, int'(o_level), 0);
   endtask
   // Called at a negedge with reset released and the unit idle in PASS.
   task automatic fwd_plus(input string tag);
      op_valid = 1'b1;
      op = "+";
      op_pc = '0;
      out_ack = 1'b0;
      cell_valid = 1'b0;
      #1;
      check({tag, ":accept"}, int'(o_op_ack), 1);
      check({tag, ":not_yet"}, int'(o_out_valid), 0);
      @(posedge clk);
      #1;
      check({tag, ":valid"}, int'(o_out_valid), 1);
      check({tag, ":op"}, int'(o_out_op), int'(8'h2B));
      op_valid = 1'b0;
      out_ack = 1'b1;
      @(negedge clk);
   endtask
   // stall < 0: random decode acceptance; otherwise acceptance held off for cycles stall..stall+3.
   task automatic run_prog(input string name, input int stall);
      logic [7:0] m [16];
      logic [7:0] held = 8'd0;
      int pc = 0, p = 0, idle = 0, cyc = 0, nld = 0, errc = 0, maxl = 0;
      m = init_mem;
      act.delete();
      ref_run();
      do_reset();
      while (1) begin
         op_valid = pc < plen;
         op = (pc < plen) ? prog[8'(pc)] : 8'd0;
         op_pc = pc[IAW-1:0];
         out_ack = (stall < 0) ? ($urandom_range(0, 3) != 0) : !(cyc >= stall && cyc < stall + 4);
         cell_valid = !o_out_valid;
         cell_zero = m[4'(p)] == 8'd0;
         #1;
         if (stall >= 0 && !out_ack && o_out_valid) begin
            if (cyc == stall) held = o_out_op;
            check({name, ":stall_op"}, int'(o_out_op), int'(held));
            check({name, ":stall_ack"}, int'(o_op_ack), 0);
         end
         if (int'(o_level) > maxl) maxl = int'(o_level);
         if (o_pc_load || o_flush) begin
            check({name, ":redirect"}, int'({o_pc_load, o_flush, o_op_ack}), 6);
            if (nld < exp_tgt.size()) check({name, ":pc_d"}, int'(o_pc_d), exp_tgt[nld]);
            nld++;
         end
         if (o_err && op_valid) check({name, ":err_ack"}, int'(o_op_ack), 0);
         if (o_out_valid && out_ack) begin
            act.push_back(o_out_op);
            if (o_out_op == "+") m[4'(p)] = m[4'(p)] + 8'd1;
            else if (o_out_op == "-") m[4'(p)] = m[4'(p)] - 8'd1;
            else if (o_out_op == ">") p++;
            else if (o_out_op == "<") p--;
         end
         if (o_op_ack) pc++;
         if (o_pc_load) pc = int'(o_pc_d);
         idle = (pc >= plen && !o_out_valid && !o_pc_load) ? idle + 1 : 0;
         errc = o_err ? errc + 1 : 0;
         cyc++;
         if (idle >= 4 || errc >= 5 || cyc >= 6000) break;
         @(negedge clk);
      end
      check({name, ":timeout"}, int'(cyc >= 6000), 0);
      check({name, ":len"}, act.size(), exp_trace.size());
      for (int i = 0; i < act.size() && i < exp_trace.size(); i++)
         check({name, ":op"}, int'(act[i]), int'(exp_trace[i]));
      check({name, ":loads"}, nld, exp_tgt.size());
      check({name, ":err"}, int'(o_err), exp_err);
      check({name, ":level"}, int'(o_level), exp_level);
      check({name, ":max_level"}, maxl, exp_maxd);
   endtask
   // Loops always end with '-' on their own cell and their bodies never touch that cell, so they terminate.
   task automatic gen_prog();
      int n, m, r, k;
      plen = 0;
      n = $urandom_range(3, 6);
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 3);
         if (k == 0) begin
            add("[");
            m = $urandom_range(1, 3);
            for (int j = 0; j < m; j++) begin
               k = $urandom_range(0, 2);
               if (k == 0) begin
                  add(">");
                  add("[");
                  r = $urandom_range(1, 2);
                  for (int q = 0; q < r; q++) begin
                     if ($urandom_range(0, 1) == 0) add(".");
                     else begin
                        add(">");
                        add("+");
                        add("<");
                     end
                  end
                  add("-");
                  add("]");
                  add("<");
               end else if (k == 1) begin
                  add(">");
                  add("+");
                  add("<");
               end else add(".");
            end
            add("-");
            add("]");
         end else if (k == 1) add(".");
         else add("+");
      end
   endtask
   initial begin
      rst = 1'b1;
      op_valid = 1'b1;
      op = "+";
      op_pc = '0;
      out_ack = 1'b0;
      cell_valid = 1'b1;
      cell_zero = 1'b0;
      #1;
      check_rst("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fwd_plus("latency");
      load("+[-]");
      set_mem(8'd0);
      run_prog("plus_loop", -1);
      load("[-]");
      set_mem(8'd3);
      run_prog("loop3", -1);
      load("[[+]]>");
      set_mem(8'd0);
      run_prog("skip_nest", -1);
      load("[[[++");
      set_mem(8'd1);
      run_prog("overflow", -1);
      load("]+");
      set_mem(8'd0);
      run_prog("underflow", -1);
      load("[[[[[[[[.");
      run_prog("skip_ovf", -1);
      load("[[[[[[[]]]]]]].");
      run_prog("skip_max", -1);
      load("+-.+-.");
      run_prog("stall", 2);
      load("[[");
      run_prog("mid_skip", -1);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check_rst("mid_skip_reset");
      @(negedge clk);
      rst = 1'b0;
      fwd_plus("after_reset");
      for (int t = 0; t < 25; t++) begin
         gen_prog();
         set_mem(8'd0);
         run_prog($sformatf("rnd%0d", t), -1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
